// File: rtl/cpu_debug_pkg.sv
// Shared types for the OCI RAM arbiter: FSM states, JTAG op kinds and jdo field positions.
package cpu_debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AV_ACC = 3'd1,
        ST_AV_ACK = 3'd2,
        ST_JT_ACC = 3'd3,
        ST_JT_CAP = 3'd4
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } jtag_op_t;

    typedef enum logic {
        SIDE_AV = 1'b0,
        SIDE_JT = 1'b1
    } side_t;

    localparam int ADDR_LSB  = 10;
    localparam int DATA_LSB  = 3;
    localparam int RDREQ_BIT = 35;

endpackage

// File: rtl/cpu_ocimem_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG command strobes and the Avalon
// debug slave, round-robin on ties. Owns jaddr, MonDReg/monitor_ready and waitrequest.
module cpu_ocimem_arbiter
    import cpu_debug_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [37:0]           jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic                  take_no_action_ocimem_a,
    output logic [DATA_W-1:0]     MonDReg,
    output logic                  monitor_ready,
    output logic                  jtag_overrun,
    input  logic [ADDR_W-1:0]     avl_address,
    input  logic                  avl_read,
    input  logic                  avl_write,
    input  logic [DATA_W-1:0]     avl_writedata,
    input  logic [DATA_W/8-1:0]   avl_byteenable,
    output logic [DATA_W-1:0]     avl_readdata,
    output logic                  avl_waitrequest,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_wren,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic [2:0]            fsm_state
);

    arb_state_t          state;
    side_t               last_grant;
    logic [ADDR_W-1:0]   jaddr;
    logic                jt_pend;
    jtag_op_t            pend_op;
    logic [DATA_W-1:0]   pend_wdata;
    logic                av_wr;
    logic                jt_wr;

    logic                sel_a;
    logic                sel_b;
    logic                sel_n;
    logic                new_valid;
    jtag_op_t            new_op;
    logic                busy;
    logic                accept;
    logic                av_req;
    logic                jt_req;
    logic                grant_jt;
    jtag_op_t            cur_op;
    logic [DATA_W-1:0]   cur_wdata;
    logic [ADDR_W-1:0]   jaddr_eff;

    logic                unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Avalon: a request is held until avl_waitrequest is sampled low; that cycle completes
    // it, and on reads avl_readdata is valid in that same cycle.
    assign avl_readdata = ram_rdata;
    assign fsm_state    = state;

    always_comb begin
        sel_a     = take_action_ocimem_a;
        sel_b     = ~take_action_ocimem_a & take_action_ocimem_b;
        sel_n     = ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;
        new_valid = (sel_a & jdo[RDREQ_BIT]) | sel_b | sel_n;
        new_op    = sel_b ? OP_WR : OP_RD;
        busy      = jt_pend || (state == ST_JT_ACC) || (state == ST_JT_CAP);
        accept    = new_valid & ~busy;
        // A fresh ocimem_a address applies to the access granted in the same cycle.
        jaddr_eff = sel_a ? jdo[ADDR_LSB +: ADDR_W] : jaddr;
        cur_op    = jt_pend ? pend_op : new_op;
        cur_wdata = jt_pend ? pend_wdata : jdo[DATA_LSB +: DATA_W];
        av_req    = avl_read | avl_write;
        jt_req    = jt_pend | accept;
        grant_jt  = jt_req & (~av_req | (last_grant == SIDE_AV));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            last_grant      <= SIDE_JT;
            jaddr           <= '0;
            jt_pend         <= 1'b0;
            pend_op         <= OP_RD;
            pend_wdata      <= '0;
            av_wr           <= 1'b0;
            jt_wr           <= 1'b0;
            MonDReg         <= '0;
            monitor_ready   <= 1'b0;
            jtag_overrun    <= 1'b0;
            avl_waitrequest <= 1'b1;
            ram_addr        <= '0;
            ram_wren        <= 1'b0;
            ram_wdata       <= '0;
            ram_be          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (jt_req && av_req) begin
                        last_grant <= grant_jt ? SIDE_JT : SIDE_AV;
                    end
                    if (grant_jt) begin
                        ram_addr  <= jaddr_eff;
                        ram_wdata <= cur_wdata;
                        ram_be    <= '1;
                        ram_wren  <= (cur_op == OP_WR);
                        jt_wr     <= (cur_op == OP_WR);
                        state     <= ST_JT_ACC;
                    end else if (av_req) begin
                        ram_addr        <= avl_address;
                        ram_wdata       <= avl_writedata;
                        ram_be          <= avl_byteenable;
                        ram_wren        <= avl_write;
                        av_wr           <= avl_write;
                        // Writes finish during the access cycle itself.
                        avl_waitrequest <= ~avl_write;
                        state           <= ST_AV_ACC;
                    end
                end
                ST_AV_ACC: begin
                    ram_wren <= 1'b0;
                    if (av_wr) begin
                        avl_waitrequest <= 1'b1;
                        state           <= ST_IDLE;
                    end else begin
                        avl_waitrequest <= 1'b0;
                        state           <= ST_AV_ACK;
                    end
                end
                ST_AV_ACK: begin
                    avl_waitrequest <= 1'b1;
                    state           <= ST_IDLE;
                end
                ST_JT_ACC: begin
                    ram_wren <= 1'b0;
                    if (jt_wr) begin
                        monitor_ready <= 1'b1;
                        jaddr         <= jaddr + ADDR_W'(1);
                        state         <= ST_IDLE;
                    end else begin
                        state <= ST_JT_CAP;
                    end
                end
                ST_JT_CAP: begin
                    MonDReg       <= ram_rdata;
                    monitor_ready <= 1'b1;
                    jaddr         <= jaddr + ADDR_W'(1);
                    state         <= ST_IDLE;
                end
                default: begin
                    ram_wren        <= 1'b0;
                    avl_waitrequest <= 1'b1;
                    state           <= ST_IDLE;
                end
            endcase

            // One-deep JTAG pending slot; a granted fresh strobe bypasses it.
            if ((state == ST_IDLE) && grant_jt) begin
                jt_pend <= 1'b0;
            end else if (accept) begin
                jt_pend    <= 1'b1;
                pend_op    <= new_op;
                pend_wdata <= jdo[DATA_LSB +: DATA_W];
            end

            if (accept) begin
                monitor_ready <= 1'b0;
            end

            // An address load always lands, overriding a same-cycle auto-increment.
            if (sel_a) begin
                jaddr        <= jdo[ADDR_LSB +: ADDR_W];
                jtag_overrun <= 1'b0;
            end else if ((sel_b || sel_n) && busy) begin
                jtag_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_ocimem_arbiter.sv
// Directed bench for cpu_ocimem_arbiter with a behavioural RAM and read-data scoreboards.
module tb_cpu_ocimem_arbiter;
    import cpu_debug_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [37:0]        jdo;
    logic               take_action_ocimem_a;
    logic               take_action_ocimem_b;
    logic               take_no_action_ocimem_a;
    logic [31:0]        MonDReg;
    logic               monitor_ready;
    logic               jtag_overrun;
    logic [ADDR_W-1:0]  avl_address;
    logic               avl_read;
    logic               avl_write;
    logic [31:0]        avl_writedata;
    logic [3:0]         avl_byteenable;
    logic [31:0]        avl_readdata;
    logic               avl_waitrequest;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_wren;
    logic [31:0]        ram_wdata;
    logic [3:0]         ram_be;
    logic [31:0]        ram_rdata;
    logic [2:0]         fsm_state;

    logic [31:0]        mem [256];
    logic [32:0]        jt_q[$];
    logic [31:0]        av_q[$];
    int                 checks = 0;
    int                 errors = 0;

    cpu_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun),
        .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
        .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
        .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
        .ram_be(ram_be), .ram_rdata(ram_rdata), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (b == 8'h20) return 32'hFFFF_FFFF;
        return {8'hA5, b, ~b, b ^ 8'h3C};
    endfunction

    function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] addr);
        logic [37:0] j;
        j = '0;
        j[35] = rd;
        j[17:10] = addr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[34:3] = data;
        return j;
    endfunction

    // Single-port RAM, registered read, byte-enabled writes; reset reloads the pattern.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else begin
            if (ram_wren) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a, 3 = ocimem_b + no_action_a together
    task automatic jt_strobe(input int kind, input logic [37:0] j, input int lat, input string tag);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1) || (kind == 3);
        take_no_action_ocimem_a = (kind == 2) || (kind == 3);
        step();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        for (int c = 1; c < lat; c++) begin
            chk({tag, "_busy"}, {31'd0, monitor_ready}, 32'd0);
            step();
        end
        chk({tag, "_done"}, {31'd0, monitor_ready}, 32'd1);
    endtask

    task automatic av_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        int n;
        n = 0;
        av_q.push_back(exp);
        avl_address = addr;
        avl_read = 1'b1;
        do begin
            step();
            n++;
        end while (avl_waitrequest && n < 20);
        chk({tag, "_lat"}, n, 32'd2);
        step();
        avl_read = 1'b0;
    endtask

    // Scoreboard: one JTAG entry per accepted op (popped on monitor_ready rising),
    // one Avalon entry per read (popped on the acknowledge cycle).
    initial begin
        logic        mr_prev;
        logic [32:0] ent;
        logic [31:0] aexp;
        mr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (monitor_ready && !mr_prev) begin
                    checks++;
                    assert (jt_q.size() != 0) else begin
                        errors++;
                        $error("FAIL jt_spurious observed=%h expected=no_completion", MonDReg);
                    end
                    if (jt_q.size() != 0) begin
                        ent = jt_q.pop_front();
                        if (ent[32]) begin
                            checks++;
                            assert (MonDReg === ent[31:0]) else begin
                                errors++;
                                $error("FAIL jt_rdata observed=%h expected=%h", MonDReg, ent[31:0]);
                            end
                        end
                    end
                end
                if (avl_read && !avl_waitrequest) begin
                    checks++;
                    assert (av_q.size() != 0) else begin
                        errors++;
                        $error("FAIL av_spurious observed=%h expected=no_ack", avl_readdata);
                    end
                    if (av_q.size() != 0) begin
                        aexp = av_q.pop_front();
                        checks++;
                        assert (avl_readdata === aexp) else begin
                            errors++;
                            $error("FAIL av_rdata observed=%h expected=%h", avl_readdata, aexp);
                        end
                    end
                end
            end
            mr_prev = monitor_ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avl_address = '0;
        avl_read = 1'b0;
        avl_write = 1'b0;
        avl_writedata = '0;
        avl_byteenable = '0;
        reset = 1'b1;
        repeat (3) step();
        chk("rst_waitreq", {31'd0, avl_waitrequest}, 32'd1);
        chk("rst_wren", {31'd0, ram_wren}, 32'd0);
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_mready", {31'd0, monitor_ready}, 32'd0);
        chk("rst_overrun", {31'd0, jtag_overrun}, 32'd0);
        chk("rst_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
        reset = 1'b0;
        step();

        // JTAG address load then three auto-incrementing writes
        jdo = jdo_a(1'b0, 8'h10);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        jt_q.push_back({1'b0, 32'h0});
        jt_strobe(1, jdo_b(32'hA), 2, "wr_a");
        jt_q.push_back({1'b0, 32'h0});
        jt_strobe(1, jdo_b(32'hB), 2, "wr_b");
        jt_q.push_back({1'b0, 32'h0});
        jt_strobe(1, jdo_b(32'hC), 2, "wr_c");
        chk("ram_10", mem[8'h10], 32'hA);
        chk("ram_11", mem[8'h11], 32'hB);
        chk("ram_12", mem[8'h12], 32'hC);
        jt_q.push_back({1'b1, init_val(8'h13)});
        jt_strobe(2, '0, 3, "rd_13");

        // Read at the top address, then a streaming read that wraps to 0
        jt_q.push_back({1'b1, init_val(8'hFF)});
        jt_strobe(0, jdo_a(1'b1, 8'hFF), 3, "rd_ff");
        jt_q.push_back({1'b1, init_val(8'h00)});
        jt_strobe(2, '0, 3, "rd_wrap");

        // First tie: Avalon wins
        av_q.push_back(init_val(8'h40));
        jt_q.push_back({1'b1, init_val(8'h50)});
        avl_address = 8'h40;
        avl_read = 1'b1;
        jdo = jdo_a(1'b1, 8'h50);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        chk("tie1_av_c1", {31'd0, avl_waitrequest}, 32'd1);
        step();
        chk("tie1_av_c2", {31'd0, avl_waitrequest}, 32'd0);
        chk("tie1_jt_c2", {31'd0, monitor_ready}, 32'd0);
        step();
        avl_read = 1'b0;
        step();
        step();
        chk("tie1_jt_c5", {31'd0, monitor_ready}, 32'd0);
        step();
        chk("tie1_jt_c6", {31'd0, monitor_ready}, 32'd1);

        // Second tie: JTAG wins, Avalon read stalls by 3 cycles
        av_q.push_back(init_val(8'h48));
        jt_q.push_back({1'b1, init_val(8'h58)});
        avl_address = 8'h48;
        avl_read = 1'b1;
        jdo = jdo_a(1'b1, 8'h58);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        chk("tie2_av_c1", {31'd0, avl_waitrequest}, 32'd1);
        step();
        step();
        chk("tie2_jt_c3", {31'd0, monitor_ready}, 32'd1);
        chk("tie2_av_c3", {31'd0, avl_waitrequest}, 32'd1);
        step();
        chk("tie2_av_c4", {31'd0, avl_waitrequest}, 32'd1);
        step();
        chk("tie2_av_c5", {31'd0, avl_waitrequest}, 32'd0);
        step();
        avl_read = 1'b0;

        // Avalon byte-enabled write, then read it back
        avl_address = 8'h20;
        avl_writedata = 32'h1234_5678;
        avl_byteenable = 4'b0011;
        avl_write = 1'b1;
        chk("avw_c0_wait", {31'd0, avl_waitrequest}, 32'd1);
        step();
        chk("avw_c1_wait", {31'd0, avl_waitrequest}, 32'd0);
        chk("avw_c1_wren", {31'd0, ram_wren}, 32'd1);
        chk("avw_c1_be", {28'd0, ram_be}, 32'h3);
        step();
        avl_write = 1'b0;
        chk("avw_c2_wait", {31'd0, avl_waitrequest}, 32'd1);
        chk("avw_ram", mem[8'h20], 32'hFFFF_5678);
        av_read(8'h20, 32'hFFFF_5678, "avr_20");

        // Write strobe while a JTAG read is in flight is dropped
        jt_q.push_back({1'b1, init_val(8'h59)});
        jdo = '0;
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        jdo = jdo_b(32'hDEAD);
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
        chk("ovr_set", {31'd0, jtag_overrun}, 32'd1);
        chk("ovr_busy", {31'd0, monitor_ready}, 32'd0);
        step();
        chk("ovr_rd_done", {31'd0, monitor_ready}, 32'd1);
        repeat (3) step();
        chk("ovr_no_extra", {31'd0, monitor_ready}, 32'd1);
        chk("ovr_ram_5a", mem[8'h5A], init_val(8'h5A));
        jdo = jdo_a(1'b0, 8'h70);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        chk("ovr_clear", {31'd0, jtag_overrun}, 32'd0);

        // ocimem_b and no_action together: only the write happens, no overrun
        jt_q.push_back({1'b0, 32'h0});
        jt_strobe(3, jdo_b(32'h77), 2, "prio_wr");
        chk("prio_ram_70", mem[8'h70], 32'h77);
        chk("prio_no_ovr", {31'd0, jtag_overrun}, 32'd0);
        jt_q.push_back({1'b1, init_val(8'h71)});
        jt_strobe(2, '0, 3, "prio_next");

        // Reset asserted during the Avalon read acknowledge
        avl_address = 8'h30;
        avl_read = 1'b1;
        step();
        step();
        chk("rstmid_ack", {31'd0, avl_waitrequest}, 32'd0);
        chk("rstmid_state_ack", {29'd0, fsm_state}, {29'd0, ST_AV_ACK});
        reset = 1'b1;
        #1;
        chk("rstmid_wait", {31'd0, avl_waitrequest}, 32'd1);
        chk("rstmid_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
        chk("rstmid_wren", {31'd0, ram_wren}, 32'd0);
        avl_read = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        av_read(8'h30, init_val(8'h30), "rst_after");

        repeat (2) step();
        chk("jt_q_empty", jt_q.size(), 32'd0);
        chk("av_q_empty", av_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ocimem_arbiter.md
# cpu_ocimem_arbiter

Sequences and arbitrates access to the CPU's single-port on-chip debug RAM (OCI RAM) between two requesters: the JTAG debug slave's system-clock command strobes (`take_action_ocimem_*`, `jdo`) and the CPU-side Avalon debug slave port. It sits beside the debug slave wrapper in the CPU subsystem. It owns the RAM port, the JTAG auto-incrementing address and `MonDReg`/`monitor_ready`, and the Avalon `waitrequest` handshake. Round-robin arbitration guarantees neither side starves.

## Interface
- `ADDR_W`, 8, OCI RAM word-address width
- `DATA_W`, 32, data width (fixed 32; `jdo` field positions assume it)
- `clk`  in  1  system clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `jdo`  in  38  JTAG data-out register, sampled only on strobes
- `take_action_ocimem_a`  in  1  load JTAG address `jdo[17:10]`; if `jdo[35]`=1, also queue a read
- `take_action_ocimem_b`  in  1  queue a write of `jdo[34:3]` to the JTAG address
- `take_no_action_ocimem_a`  in  1  queue a read at the JTAG address (streaming read)
- `MonDReg`  out  32  last JTAG read data
- `monitor_ready`  out  1  JTAG op complete
- `jtag_overrun`  out  1  sticky flag: a JTAG strobe was dropped
- `avl_address`  in  ADDR_W  Avalon word address
- `avl_read`, `avl_write`  in  1  Avalon requests, never both set
- `avl_writedata`  in  32  Avalon write data
- `avl_byteenable`  in  4  Avalon byte enables
- `avl_readdata`  out  32  Avalon read data, valid when `avl_read & ~avl_waitrequest`
- `avl_waitrequest`  out  1  Avalon stall
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wren`  out  1  RAM write strobe
- `ram_wdata`  out  32  RAM write data
- `ram_be`  out  4  RAM byte enables; JTAG writes use 4'hF
- `ram_rdata`  in  32  RAM read data, registered, 1-cycle latency

## Operation
- JTAG side: one-deep pending register holding op type (RD/WR) and write data. It operates on `jaddr`.
- A strobe is accepted when no JTAG op is pending or in flight.
  - On acceptance, clear `monitor_ready` the next cycle.
- A strobe that arrives while a JTAG op is busy is dropped and sets `jtag_overrun`.
  - Exception: an `ocimem_a` strobe still loads `jaddr` and clears `jtag_overrun`; only its queued read is dropped.
- Strobe priority if several fire in one cycle: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority strobes are ignored without setting the overrun flag.
- JTAG op completion:
  - Read: `MonDReg` <= `ram_rdata`.
  - Both reads and writes: set `monitor_ready`, then `jaddr` <= `jaddr`+1, wrapping from 2^ADDR_W−1 to 0.
- FSM states:
  - IDLE: grant. If only one requester is pending, grant it. If both are pending, grant the side opposite `last_grant`, then update `last_grant`. Next state is AV_ACC or JT_ACC.
  - AV_ACC: drive the Avalon address. For a write, assert `ram_wren` and set `avl_waitrequest`=0, then go to IDLE. For a read, go to AV_ACK.
  - AV_ACK: `avl_waitrequest`=0, `avl_readdata`=`ram_rdata`, then go to IDLE.
  - JT_ACC: drive `jaddr`. For a write, assert `ram_wren` and complete, then go to IDLE. For a read, go to JT_CAP.
  - JT_CAP: capture `MonDReg`, complete, then go to IDLE.
- `avl_waitrequest`=1 in every other state, including IDLE with a request pending.
- When no access is active, RAM outputs are don't-care except `ram_wren`, which must be 0.

## Timing
- Reset values:
  - outputs: `MonDReg`=0, `monitor_ready`=0, `jtag_overrun`=0, `avl_waitrequest`=1, `ram_wren`=0
  - internal: `jaddr`=0, `last_grant`=JTAG (so Avalon wins the first tie), FSM=IDLE, pending cleared
- Avalon latency with the port uncontended, request seen in cycle 0:
  - write: `waitrequest` low in cycle 1
  - read: `waitrequest` low in cycle 2
- JTAG latency, strobe in cycle 0: write sets `monitor_ready` in cycle 2; read sets it in cycle 3.
- Worst-case Avalon stall behind one JTAG read: +3 cycles.
- Reset asserted mid-operation: everything returns to reset values immediately; an in-flight write may or may not land in RAM.

## Structure
- Shared package `cpu_debug_pkg`:
  - FSM state enum
  - `jdo` field constants: ADDR_LSB=10, DATA_LSB=3, RDREQ_BIT=35
  - JTAG op enum
- Single module. No submodule is needed: the pending register and FSM are tightly coupled.

## Test plan
- Reset, then `ocimem_a` with `jdo[17:10]`=8'h10, then three `ocimem_b` writes of 0xA, 0xB, 0xC -> RAM[0x10..0x12]=A, B, C; `monitor_ready` high 2 cycles after each strobe; `jaddr`=0x13.
- `ocimem_a` addr 8'hFF with `jdo[35]`=1, then `take_no_action_ocimem_a` -> `MonDReg`=RAM[0xFF], then RAM[0x00] (wrap).
- Avalon read and JTAG read pending in the same cycle from reset -> Avalon granted first. On the next tie, JTAG is granted first.
- Avalon write of 0x12345678 with `byteenable`=4'b0011 to 0x20 holding 0xFFFFFFFF -> RAM=0xFFFF5678; `waitrequest` low exactly 1 cycle after the request.
- `ocimem_b` strobe while a JTAG read is in flight -> write dropped, `jtag_overrun`=1. A subsequent `ocimem_a` clears the flag.
- `reset` asserted during AV_ACK -> `avl_waitrequest`=1 and FSM=IDLE in the same cycle; after release, a new Avalon read completes normally.
